// File: rtl/alu_result_tx_if.sv
// Handshake bundle between the ALU/UART side and the alu_result_tx sequencer.
// The slave modport is the sequencer's view; the master modport is the surrounding logic's view.
interface alu_result_tx_if #(
    parameter int NB_DATA = 8
);
    logic [NB_DATA-1:0] i_result;
    logic               i_carry;
    logic               i_zero;
    logic               i_valid;
    logic               o_ready;
    logic               i_tx_busy;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_done;
    logic               o_overrun;

    modport slave (
        input  i_result, i_carry, i_zero, i_valid, i_tx_busy,
        output o_ready, o_tx_data, o_tx_start, o_done, o_overrun
    );

    modport master (
        output i_result, i_carry, i_zero, i_valid, i_tx_busy,
        input  o_ready, o_tx_data, o_tx_start, o_done, o_overrun
    );
endinterface

// File: rtl/alu_result_tx.sv
// Captures an ALU result (and optionally its flags) and sends it to the UART TX one byte at a time.
// Define ALU_TX_FLAGS_EN to append the flags byte {0.., zero, carry} after the result byte.
//
// state | meaning
// IDLE  | ready for a new result
// START | byte presented, start pulsed once the UART is not busy
// ACK   | waiting for busy to rise, or for the ack timeout
// DRAIN | waiting for busy to fall before the next byte / done
module alu_result_tx #(
    parameter int NB_DATA     = 8,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    alu_result_tx_if.slave       bus
);
    typedef enum logic [1:0] {IDLE, START, ACK, DRAIN} state_t;

    localparam int                CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [NB_DATA-1:0] tx_data_q;
    logic               done_q;
    logic               overrun_q;
    logic               last_byte;

`ifdef ALU_TX_FLAGS_EN
    logic [NB_DATA-1:0] flags_q;
    logic               idx_q;
    assign last_byte = idx_q;
`else
    logic unused_flags;
    assign unused_flags = bus.i_carry ^ bus.i_zero;
    assign last_byte    = 1'b1;
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.i_valid) state_d = START;
            START:   if (!bus.i_tx_busy) state_d = ACK;
            ACK:     if (bus.i_tx_busy || cnt_q == CNT_LAST) state_d = DRAIN;
            DRAIN:   if (!bus.i_tx_busy) state_d = last_byte ? IDLE : START;
            default: state_d = IDLE;
        endcase
    end

    // Start is gated by busy directly so it can never fire into a busy transmitter.
    always_comb begin
        bus.o_ready    = (state_q == IDLE);
        bus.o_tx_start = (state_q == START) && !bus.i_tx_busy;
    end

    assign bus.o_tx_data = tx_data_q;
    assign bus.o_done    = done_q;
    assign bus.o_overrun = overrun_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q     <= '0;
            tx_data_q <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef ALU_TX_FLAGS_EN
            flags_q   <= '0;
            idx_q     <= 1'b0;
`endif
        end else begin
            done_q <= (state_q == DRAIN) && !bus.i_tx_busy && last_byte;
            if (bus.i_valid && state_q != IDLE) overrun_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (bus.i_valid) begin
                        tx_data_q <= bus.i_result;
`ifdef ALU_TX_FLAGS_EN
                        flags_q   <= {{(NB_DATA-2){1'b0}}, bus.i_zero, bus.i_carry};
                        idx_q     <= 1'b0;
`endif
                    end
                end
                START: begin
                    if (!bus.i_tx_busy) cnt_q <= '0;
                end
                ACK: begin
                    if (!bus.i_tx_busy && cnt_q != CNT_LAST) cnt_q <= cnt_q + 1'b1;
                end
                DRAIN: begin
`ifdef ALU_TX_FLAGS_EN
                    if (!bus.i_tx_busy && !last_byte) begin
                        idx_q     <= 1'b1;
                        tx_data_q <= flags_q;
                    end
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_result_tx.sv
// Directed bench for alu_result_tx: reset, frame content, busy gating, overrun, timeout, back-to-back.
module tb_alu_result_tx;
    localparam int NB_DATA = 8;
`ifdef ALU_TX_FLAGS_EN
    localparam int NBYTES = 2;
`else
    localparam int NBYTES = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_result_tx_if #(.NB_DATA(NB_DATA)) bus();

    alu_result_tx #(.NB_DATA(NB_DATA), .ACK_TIMEOUT(4)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // UART model: busy rises one cycle after a start pulse and stays up for a while.
    logic bus_mode   = 1'b0;
    logic pre_busy   = 1'b0;
    logic model_busy = 1'b0;
    logic dly        = 1'b0;
    int   hold       = 0;
    int   cyc        = 0;

    assign bus.i_tx_busy = model_busy | pre_busy;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dly) begin
            model_busy <= 1'b1;
            hold       <= 10;
        end else if (hold > 0) begin
            hold <= hold - 1;
            if (hold == 1) model_busy <= 1'b0;
        end
        dly <= bus.o_tx_start && bus_mode;
    end

    logic [NB_DATA-1:0] start_data[$];
    int                 start_cyc[$];

    always @(negedge clk) begin
        if (rst_n && bus.o_tx_start) begin
            start_data.push_back(bus.o_tx_data);
            start_cyc.push_back(cyc);
            chk_eq("start_while_busy", {31'b0, bus.i_tx_busy}, 32'd0);
        end
    end

    task automatic pulse_valid(input logic [7:0] res, input logic c, input logic z);
        @(posedge clk); #1;
        bus.i_result = res; bus.i_carry = c; bus.i_zero = z; bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
    endtask

    // Returns at the negedge of the o_done cycle.
    task automatic wait_done(input string tag, output int done_cyc);
        done_cyc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.o_done) begin
                done_cyc = cyc;
                break;
            end
        end
        if (done_cyc < 0) chk_eq({tag, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic chk_frame(input string tag, input logic [7:0] res, input logic [7:0] flg);
        chk_eq({tag, "_nstarts"}, start_data.size(), NBYTES);
        if (start_data.size() > 0) chk_eq({tag, "_byte0"}, start_data[0], res);
        if (NBYTES == 2 && start_data.size() > 1) chk_eq({tag, "_byte1"}, start_data[1], flg);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_eq({tag, "_ready"},   bus.o_ready,    1);
        chk_eq({tag, "_start"},   bus.o_tx_start, 0);
        chk_eq({tag, "_done"},    bus.o_done,     0);
        chk_eq({tag, "_overrun"}, bus.o_overrun,  0);
        chk_eq({tag, "_data"},    bus.o_tx_data,  0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int dc;
        int n0;
        bus.i_result = '0; bus.i_carry = 1'b0; bus.i_zero = 1'b0; bus.i_valid = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("rst0");
        rst_n = 1'b1;

        // Single frame with busy handshake
        bus_mode = 1'b1;
        start_data.delete(); start_cyc.delete();
        pulse_valid(8'hA5, 1'b1, 1'b0);
        @(negedge clk);
        chk_eq("f1_ready_low", bus.o_ready, 0);
        chk_eq("f1_start_k1",  bus.o_tx_start, 1);
        chk_eq("f1_data_k1",   bus.o_tx_data, 8'hA5);
        wait_done("f1", dc);
        chk_eq("f1_ready_at_done", bus.o_ready, 1);
        chk_frame("f1", 8'hA5, 8'h01);
        @(negedge clk);
        chk_eq("f1_done_pulse", bus.o_done, 0);
        chk_eq("f1_overrun_clear", bus.o_overrun, 0);

        // Overrun during a frame
        start_data.delete(); start_cyc.delete();
        pulse_valid(8'hA5, 1'b1, 1'b0);
        pulse_valid(8'hFF, 1'b0, 1'b1);
        @(negedge clk);
        chk_eq("ov_set", bus.o_overrun, 1);
        wait_done("ov", dc);
        chk_frame("ov", 8'hA5, 8'h01);
        repeat (15) @(negedge clk);
        chk_eq("ov_sticky", bus.o_overrun, 1);
        chk_eq("ov_no_extra_start", start_data.size(), NBYTES);
        chk_eq("ov_idle", bus.o_ready, 1);

        // Busy already high when the result arrives
        start_data.delete(); start_cyc.delete();
        pre_busy = 1'b1;
        pulse_valid(8'h5A, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_eq("pb_start_withheld", bus.o_tx_start, 0);
        end
        @(posedge clk); #1 pre_busy = 1'b0;
        @(negedge clk);
        chk_eq("pb_start_released", bus.o_tx_start, 1);
        chk_eq("pb_data", bus.o_tx_data, 8'h5A);
        wait_done("pb", dc);
        chk_frame("pb", 8'h5A, 8'h02);
        repeat (15) @(negedge clk);

        // Ack timeout and back-to-back frames
        bus_mode = 1'b0;
        start_data.delete(); start_cyc.delete();
        pulse_valid(8'h3C, 1'b0, 1'b0);
        wait_done("to1", dc);
        chk_frame("to1", 8'h3C, 8'h00);
        if (start_cyc.size() > 0) chk_eq("to1_latency", dc - start_cyc[0], 6 * NBYTES);
        if (NBYTES == 2 && start_cyc.size() > 1) chk_eq("to1_byte_gap", start_cyc[1] - start_cyc[0], 6);
        n0 = start_data.size();
        bus.i_result = 8'h81; bus.i_carry = 1'b1; bus.i_zero = 1'b1; bus.i_valid = 1'b1;
        @(posedge clk); #1 bus.i_valid = 1'b0;
        @(negedge clk);
        chk_eq("b2b_start", bus.o_tx_start, 1);
        chk_eq("b2b_data", bus.o_tx_data, 8'h81);
        chk_eq("b2b_ready_low", bus.o_ready, 0);
        wait_done("to2", dc);
        chk_eq("to2_nstarts", start_data.size() - n0, NBYTES);
        if (start_cyc.size() > n0) chk_eq("to2_latency", dc - start_cyc[n0], 6 * NBYTES);
        if (NBYTES == 2 && start_data.size() > n0 + 1) chk_eq("to2_byte1", start_data[n0+1], 8'h03);
        chk_eq("to_overrun_still", bus.o_overrun, 1);

        // Reset in the middle of a frame
        bus_mode = 1'b1;
        start_data.delete(); start_cyc.delete();
        pulse_valid(8'h77, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("rst_mid");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_eq("rst_hold_start", bus.o_tx_start, 0);
            chk_eq("rst_hold_done", bus.o_done, 0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk_eq("rst_rel_ready", bus.o_ready, 1);
        n0 = start_data.size();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk_eq("rst_rel_no_done", bus.o_done, 0);
        end
        chk_eq("rst_rel_no_start", start_data.size(), n0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_result_tx.md
# alu_result_tx

Transmit-side sequencer between the ALU result and the UART transmitter. It captures an ALU result and its carry/zero flags on a valid pulse. It then sends them as a frame of UART bytes, handshaking each byte with the transmitter through a start pulse and the transmitter's busy line. It is the return path that mirrors the receive-side operand/opcode assembler.

## Interface
Parameters:
- NB_DATA, 8, width of the ALU result and of each UART byte
- ACK_TIMEOUT, 4, cycles to wait for i_tx_busy to rise after a start pulse before the byte counts as sent

Ports:
- i_clk  input  1  system clock, all logic on rising edge
- i_reset  input  1  asynchronous, active-low reset
- i_result  input  NB_DATA  ALU result
- i_carry  input  1  ALU carry flag
- i_zero  input  1  ALU zero flag
- i_valid  input  1  one-cycle pulse, result/flags valid
- o_ready  output  1  high when idle and able to accept i_valid
- i_tx_busy  input  1  UART TX busy
- o_tx_data  output  NB_DATA  byte presented to UART TX
- o_tx_start  output  1  one-cycle pulse, UART TX loads o_tx_data
- o_done  output  1  one-cycle pulse, frame fully transmitted
- o_overrun  output  1  sticky, i_valid arrived while not ready

## Operation
- Reset (i_reset=0, immediate): state IDLE, o_ready=1, o_tx_start=0, o_done=0, o_overrun=0, o_tx_data=0, capture registers=0, byte index=0, timeout counter=0.
- FSM states:
  - IDLE: o_ready=1. On i_valid, capture i_result, and capture the flags byte {(NB_DATA-2)'b0, i_zero, i_carry}. Byte index=0. Go to START.
  - START: o_tx_data=byte[index]. When i_tx_busy=0, pulse o_tx_start for one cycle, clear the timeout counter, and go to ACK. While i_tx_busy=1, hold.
  - ACK: wait for i_tx_busy=1, then go to DRAIN. If ACK_TIMEOUT cycles elapse without busy, go to DRAIN.
  - DRAIN: wait for i_tx_busy=0. If more bytes remain, increment index and go to START. Otherwise go to IDLE and pulse o_done.
- Frame content: byte0=result. byte1=flags only when ALU_TX_FLAGS_EN is defined.
- o_tx_data holds its value from the START state until the next byte is loaded. It never changes while a byte is in flight.
- Overrun: i_valid while o_ready=0 is discarded and sets o_overrun=1. Only reset clears o_overrun. The frame in progress is unaffected.
- o_tx_start is never asserted while i_tx_busy=1, and never more than once per byte.

## Timing
- i_valid sampled at edge k in IDLE: o_ready=0 from k+1. START is entered at k+1. With i_tx_busy=0, o_tx_start=1 during cycle k+1 and deasserts at k+2.
- Timeout counter: counts ACK cycles. A byte that never raises busy leaves ACK after exactly ACK_TIMEOUT cycles.
- Busy falling edge seen at edge m in DRAIN on the last byte: o_done=1 and o_ready=1 during cycle m+1.
- i_valid during the o_done cycle is accepted (the state is IDLE). That gives back-to-back frames with no bubble.
- Two consecutive bytes: the next o_tx_start comes no earlier than one cycle after i_tx_busy is sampled low in DRAIN.
- Reset mid-frame: the frame is abandoned. No o_done, no further o_tx_start. After reset release, behaviour starts from IDLE.

## Configuration
- ALU_TX_FLAGS_EN defined: 2-byte frame (result, then flags). Index wraps 0→1→IDLE.
- ALU_TX_FLAGS_EN undefined: 1-byte frame (result only). Flag inputs are unused and there is no flags capture register. o_done follows the result byte.

## Test plan
- Reset: hold i_reset=0 for 3 cycles mid-frame → all outputs at reset values immediately, no o_tx_start. After release, o_ready=1.
- Single frame (flags enabled): i_result=8'hA5, i_carry=1, i_zero=0, i_valid pulse. Bus model raises busy 1 cycle after start and holds it 10 cycles → o_tx_data=8'hA5 with a start pulse, then 8'h01 with a start pulse, then one o_done. Exactly 2 starts.
- Flags disabled build: i_result=8'h3C → one start with 8'h3C, then o_done. No second byte.
- Busy pre-asserted: i_tx_busy=1 when i_valid arrives and stays high 5 cycles → o_tx_start is withheld until the cycle busy is sampled low.
- Overrun: a second i_valid (8'hFF) 2 cycles into the frame → o_overrun=1 and stays 1. The transmitted bytes are still 8'hA5/8'h01.
- Timeout and back-to-back: the bus model never raises busy → each byte leaves ACK after 4 cycles. i_valid in the o_done cycle → a new frame starts the next cycle.
